timer_countdown_core: RTL
=========================

Name: timer_countdown_core

Overview:
- Countdown timer core that holds the minutes and seconds values and decrements them once per second. It runs a start/pause/done state machine.
- It sits directly upstream of the binary-to-BCD converters. The `minutes` and `seconds` outputs (0..59, 6-bit) each feed one converter instance, which then drives the display digits.
- It also generates its own 1 Hz enable from the system clock.

Parameters:
- TICKS_PER_SEC, 100000000: clk cycles per timer second. Must be >= 2. The bench uses 4.
- PRESC_W, 27: width of the prescaler counter. Must satisfy 2^PRESC_W > TICKS_PER_SEC.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; captures set_min/set_sec.
- set_min  input  6  minutes to load. Values >59 saturate to 59.
- set_sec  input  6  seconds to load. Values >59 saturate to 59.
- start_stop  input  1  one-cycle strobe; start / pause / resume / acknowledge.
- minutes  output  6  current minutes, 0..59, registered.
- seconds  output  6  current seconds, 0..59, registered.
- running  output  1  high while in state RUN.
- done  output  1  high while in state DONE.
- sec_tick  output  1  one-cycle pulse on every clk edge where the time decrements.

Behaviour:
- Reset: on a clk edge with rst=1, the block goes to state=IDLE, minutes=0, seconds=0, prescaler=0, running=0, done=0, sec_tick=0. rst overrides all other inputs, including mid-countdown.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered. running and done decode the state register.
- Input priority per edge: rst > load > start_stop. If load and start_stop are both high, only load acts.
- load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Next edge: minutes = min(set_min,59), seconds = min(set_sec,59), prescaler = 0, state = IDLE.
- start_stop transitions:
  - IDLE -> RUN if {minutes,seconds} != 0; otherwise stay in IDLE (no-op). Entering RUN from IDLE clears the prescaler.
  - RUN -> PAUSE. The prescaler value is retained, so a partial second survives a pause.
  - PAUSE -> RUN. The prescaler resumes from its held value.
  - DONE -> IDLE. minutes and seconds remain 00:00.
- Prescaler:
  - Advances only in RUN.
  - Counts 0..TICKS_PER_SEC-1 and wraps to 0.
  - The terminal count (TICKS_PER_SEC-1) in RUN is the tick edge.
  - First decrement occurs TICKS_PER_SEC edges after the RUN entry edge.
- Tick edge (RUN only):
  - sec_tick = 1 on the following cycle (registered alongside the new time).
  - If seconds > 0: seconds -= 1.
  - Else if minutes > 0: minutes -= 1 and seconds = 59.
  - If the resulting value is 00:00, state = DONE on the same edge. running falls and done rises with the 00:00 display.
- Pause on a tick edge: if start_stop arrives on the same edge as a tick, the decrement is not applied. State goes to PAUSE, and the prescaler holds at terminal count. The decrement is applied on the first RUN edge after resume.
- DONE: time is frozen at 00:00 and the prescaler is held. Only start_stop (acknowledge), load or rst leave this state.
- Arithmetic rules:
  - No value outside 0..59 is ever produced on minutes or seconds.
  - The decrement never underflows; 00:00 is terminal.

Test Plan:
- Reset mid-countdown:
  - Load 05:30, start, run 3 seconds, assert rst for 1 cycle.
  - Next edge: minutes=0, seconds=0, running=0, done=0, state IDLE.
- Load clamp and RUN gating:
  - set_min=63, set_sec=60, load → minutes=59, seconds=59.
  - Pulse load while running → time unchanged.
- Minute borrow (TICKS_PER_SEC=4):
  - Load 01:01, start.
  - Required sequence 01:00, 00:59 at 4-cycle spacing, with exactly one sec_tick per step.
- Expiry:
  - Load 00:02, start.
  - After 8 cycles: 00:00, done=1, running=0.
  - Further cycles: unchanged.
  - start_stop → IDLE, done=0.
- Pause/resume retains the partial second:
  - Load 00:10, start, wait 2 cycles, pause 20 cycles, resume.
  - Next decrement (to 00:09) occurs 2 cycles after resume.
- Simultaneous and zero cases:
  - load + start_stop in the same cycle while in PAUSE → loaded value, state IDLE, not running.
  - start_stop while IDLE at 00:00 → stays IDLE.

Source files
------------

// File: rtl/timer_countdown_core.sv
// Minutes/seconds countdown core with a start/pause/done FSM and a built-in
// prescaler that turns clk into a once-per-second decrement enable.
//
// state | meaning
// IDLE  | time loaded or cleared, waiting for start_stop
// RUN   | prescaler advancing, time decrements on terminal count
// PAUSE | countdown frozen, prescaler holds the partial second
// DONE  | reached 00:00, waiting for acknowledge or load
module timer_countdown_core #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int PRESC_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  input  logic       start_stop,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       done,
  output logic       sec_tick
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [5:0]         MAX_VAL  = 6'd59;

  state_t             state_q, state_d;
  logic [5:0]         min_q, min_d;
  logic [5:0]         sec_q, sec_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    presc_d = presc_q;
    tick_d  = 1'b0;

    if (load && state_q != RUN) begin
      min_d   = (set_min > MAX_VAL) ? MAX_VAL : set_min;
      sec_d   = (set_sec > MAX_VAL) ? MAX_VAL : set_sec;
      presc_d = '0;
      state_d = IDLE;
    end else if (start_stop) begin
      // A strobe landing on a tick edge wins; the held terminal count
      // makes the skipped decrement happen right after resume.
      case (state_q)
        IDLE: begin
          if ({min_q, sec_q} != 12'd0) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (state_q == RUN) begin
      if (presc_q == PRESC_TC) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (sec_q != 6'd0) begin
          sec_d = sec_q - 6'd1;
        end else if (min_q != 6'd0) begin
          min_d = min_q - 6'd1;
          sec_d = MAX_VAL;
        end
        if ({min_d, sec_d} == 12'd0) begin
          state_d = DONE;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sec_tick = tick_q;

endmodule
